pong_game_state: RTL



---
 rtl/pong_game_state.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pong_game_state.sv
// pong_game_state: per-frame Pong engine; frame_tick-gated buttons/start in, registered paddle centres, ball centre, scores and game_over out
module pong_game_state #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_R       = 4,
  parameter int BALL_SPEED   = 2,
  parameter int LEFT_FACE    = 24,
  parameter int RIGHT_FACE   = 616,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       left_up,
  input  logic       left_down,
  input  logic       right_up,
  input  logic       right_down,
  input  logic       start,
  output logic [9:0] leftPaddle,
  output logic [9:0] rightPaddle,
  output logic [9:0] ball_center_x,
  output logic [9:0] ball_center_y,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       game_over
);
  typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;
  localparam int CW = $clog2(SERVE_FRAMES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [9:0] P_MIN = 10'(PADDLE_H / 2);
  localparam logic [9:0] P_MAX = 10'(SCREEN_H - 1 - PADDLE_H / 2);
  localparam logic [9:0] STEP = 10'(PADDLE_STEP);
  localparam logic [9:0] CX = 10'(SCREEN_W / 2);
  localparam logic [9:0] CY = 10'(SCREEN_H / 2);
  localparam logic [3:0] WIN_M1 = 4'(WIN_SCORE - 1);
  localparam logic signed [10:0] SPD = 11'(BALL_SPEED);
  localparam logic signed [10:0] BR = 11'(BALL_R);
  localparam logic signed [10:0] BOT = 11'(SCREEN_H - 1 - BALL_R);
  localparam logic signed [10:0] XMAX = 11'(SCREEN_W - 1 - BALL_R);
  localparam logic signed [10:0] LHIT = 11'(LEFT_FACE + BALL_R);
  localparam logic signed [10:0] RHIT = 11'(RIGHT_FACE - BALL_R);
  localparam logic signed [10:0] REACH = 11'(PADDLE_H / 2 + BALL_R);
  state_t state;
  logic [CW-1:0] serve_cnt;
  logic dx, dy;
  logic [9:0] lp_next, rp_next;
  logic signed [10:0] x_s, y_s, nx, ny, dl, dr, al, ar, y_wall, x_next;
  logic hit_l, hit_r, miss_l, miss_r, dy_wall, dx_next;
  function automatic logic [9:0] move(input logic [9:0] y, input logic up, input logic dn);
    return (up && !dn) ? ((y < P_MIN + STEP) ? P_MIN : y - STEP) :
           (dn && !up) ? ((y > P_MAX - STEP) ? P_MAX : y + STEP) : y;
  endfunction
  always_comb begin
    lp_next = move(leftPaddle, left_up, left_down);
    rp_next = move(rightPaddle, right_up, right_down);
    x_s = $signed({1'b0, ball_center_x});
    y_s = $signed({1'b0, ball_center_y});
    nx = x_s + (dx ? SPD : -SPD);
    ny = y_s + (dy ? SPD : -SPD);
    dl = y_s - $signed({1'b0, leftPaddle});
    dr = y_s - $signed({1'b0, rightPaddle});
    al = dl[10] ? -dl : dl;
    ar = dr[10] ? -dr : dr;
    hit_l = !dx && x_s >= LHIT && nx <= LHIT && al <= REACH;
    hit_r = dx && x_s <= RHIT && nx >= RHIT && ar <= REACH;
    miss_l = !hit_l && nx <= BR;
    miss_r = !hit_r && nx >= XMAX;
    y_wall = (ny <= BR) ? BR : (ny >= BOT) ? BOT : ny;
    dy_wall = (ny <= BR) ? 1'b1 : (ny >= BOT) ? 1'b0 : dy;
    x_next = hit_l ? LHIT : hit_r ? RHIT : nx;
    dx_next = hit_l ? 1'b1 : hit_r ? 1'b0 : dx;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SERVE;
      serve_cnt <= '0;
      leftPaddle <= CY;
      rightPaddle <= CY;
      ball_center_x <= CX;
      ball_center_y <= CY;
      dx <= 1'b1;
      dy <= 1'b1;
      left_score <= '0;
      right_score <= '0;
      game_over <= 1'b0;
    end else if (frame_tick) begin
      if (state != OVER) begin
        leftPaddle <= lp_next;
        rightPaddle <= rp_next;
      end
      case (state)
        SERVE: begin
          serve_cnt <= (serve_cnt == CNT_LAST) ? '0 : serve_cnt + 1'b1;
          if (serve_cnt == CNT_LAST) state <= PLAY;
        end
        PLAY: begin
          if (miss_l || miss_r) begin
            ball_center_x <= CX;
            ball_center_y <= CY;
            dx <= miss_r;
            dy <= 1'b1;
            if (miss_l) right_score <= right_score + 1'b1;
            else left_score <= left_score + 1'b1;
            state <= ((miss_l ? right_score : left_score) == WIN_M1) ? OVER : SERVE;
            game_over <= (miss_l ? right_score : left_score) == WIN_M1;
          end else begin
            ball_center_x <= x_next[9:0];
            ball_center_y <= y_wall[9:0];
            dx <= dx_next;
            dy <= dy_wall;
          end
        end
        OVER: begin
          if (start) begin
            left_score <= '0;
            right_score <= '0;
            game_over <= 1'b0;
            dx <= 1'b1;
            dy <= 1'b1;
            serve_cnt <= '0;
            state <= SERVE;
          end
        end
        default: state <= SERVE;
      endcase
    end
  end
endmodule
